// File: rtl/pru_cmd_queue.sv
// Command word FIFO feeding the PRU preprocessor in two-word pairs.
// Optional WAIT_DONE watchdog enabled by defining PRU_CMD_TIMEOUT_EN.
module pru_cmd_queue #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     host_wr,
    input  logic [31:0]              host_data,
    output logic                     host_full,
    output logic [$clog2(DEPTH):0]   host_count,
    input  logic                     flush,
    input  logic                     pru_busy,
    input  logic                     pru_done,
    output logic                     pp_write,
    output logic [31:0]              pp_data,
    output logic                     overflow,
    output logic                     timeout_err,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        GAP,
        ISSUE1,
        WAIT_DONE
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [31:0] mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        full;
    logic        push;
    logic        pop;
    logic        ovf_set;
    logic        tmo_set;

    assign full       = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                        (wptr[AW] != rptr[AW]);
    assign host_full  = full;
    assign host_count = wptr - rptr;

    // flush discards a same-cycle write without flagging overflow
    assign push    = host_wr && !full && !flush;
    assign ovf_set = host_wr && full && !flush;
    assign pop     = (state == ISSUE0) || (state == ISSUE1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= host_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // strobe and data are registered one cycle behind the issue states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_write <= 1'b0;
            pp_data  <= '0;
        end else begin
            pp_write <= pop;
            if (pop) begin
                pp_data <= mem[rptr[AW-1:0]];
            end
        end
    end

`ifdef PRU_CMD_TIMEOUT_EN
    logic [31:0] tcnt;
    logic        expired;

    assign expired = (tcnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (state == ISSUE1) begin
            tcnt <= '0;
        end else if (state == WAIT_DONE) begin
            tcnt <= tcnt + 1'b1;
        end
    end
`else
    logic expired;
    logic tmo_unused;

    assign expired    = 1'b0;
    assign tmo_unused = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_n = state;
        tmo_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (host_count >= (AW+1)'(2) && !pru_busy) begin
                    state_n = ISSUE0;
                end
            end
            ISSUE0: state_n = GAP;
            GAP:    state_n = ISSUE1;
            ISSUE1: state_n = WAIT_DONE;
            WAIT_DONE: begin
                if (pru_done) begin
                    state_n = IDLE;
                end else if (expired) begin
                    state_n = IDLE;
                    tmo_set = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (flush) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clr_err) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end
    end

`ifdef PRU_CMD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (clr_err) begin
            timeout_err <= 1'b0;
        end else if (tmo_set) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pru_cmd_queue.sv
// Bench for pru_cmd_queue: vector table, corner sequences, random vs model.
module tb_pru_cmd_queue;

    localparam int DEPTH = 16;
    localparam int TMO   = 100;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          host_wr;
    logic [31:0]   host_data;
    logic          host_full;
    logic [CW-1:0] host_count;
    logic          flush;
    logic          pru_busy;
    logic          pru_done;
    logic          pp_write;
    logic [31:0]   pp_data;
    logic          overflow;
    logic          timeout_err;
    logic          clr_err;

    pru_cmd_queue #(
        .DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .host_wr(host_wr),
        .host_data(host_data),
        .host_full(host_full),
        .host_count(host_count),
        .flush(flush),
        .pru_busy(pru_busy),
        .pru_done(pru_done),
        .pp_write(pp_write),
        .pp_data(pp_data),
        .overflow(overflow),
        .timeout_err(timeout_err),
        .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ev_cyc[$];
    logic [31:0] ev_dat[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pp_write === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_dat.push_back(pp_data);
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] d;
        logic        done;
        logic        e_wr;
        logic [31:0] e_data;
        int          e_cnt;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp,
                     $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        host_wr   = 1'b0;
        host_data = '0;
        flush     = 1'b0;
        pru_busy  = 1'b0;
        pru_done  = 1'b0;
        clr_err   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ev_cyc.delete();
        ev_dat.delete();
    endtask

    task automatic push(input logic [31:0] d);
        host_wr   = 1'b1;
        host_data = d;
        tick();
        host_wr   = 1'b0;
    endtask

    task automatic wait_events(input int n, input int budget,
                               input string nm);
        int k = 0;
        while (ev_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(nm, ev_cyc.size(), n);
    endtask

    task automatic wait_word(input logic [31:0] w, input string nm);
        int k = 0;
        while (!(pp_write === 1'b1 && pp_data === w) && k < 40) begin
            tick();
            k++;
        end
        chk(nm, {pp_write, pp_data == w}, 2'b11);
    endtask

    logic [31:0] q[$];
    bit          act;
    int          el;
    logic        m_wr;
    logic [31:0] m_data;
    logic        m_ovf;
    logic        m_tmo;

    task automatic model_step(input logic wr, input logic [31:0] d,
                              input logic busy, input logic done,
                              input logic fl, input logic clr);
        int  sz;
        bit  expire;
        sz     = q.size();
        expire = 0;
        m_wr   = act && (el == 0 || el == 2);
        if (m_wr) m_data = q.pop_front();
        if (wr && !fl && sz < DEPTH) q.push_back(d);
        m_ovf = clr ? 1'b0 : (m_ovf | (wr && !fl && sz == DEPTH));
        if (act && el >= 3) begin
            if (done) act = 0;
`ifdef PRU_CMD_TIMEOUT_EN
            else if (el - 3 == TMO - 1) begin
                act    = 0;
                expire = 1;
            end
`endif
            else el++;
        end else if (act) begin
            el++;
        end else if (sz >= 2 && !busy) begin
            act = 1;
            el  = 0;
        end
        m_tmo = clr ? 1'b0 : (m_tmo | expire);
        if (fl) begin
            q.delete();
            act = 0;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int tp;
    int td;

    initial begin
        tv[0] = '{1'b1, 32'h07C1414B, 1'b0, 1'b0, 32'h0, 1};
        tv[1] = '{1'b1, 32'h0000020F, 1'b0, 1'b0, 32'h0, 2};
        tv[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2};
        tv[3] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h07C1414B, 1};
        tv[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h07C1414B, 1};
        tv[5] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0000020F, 0};
        tv[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0000020F, 0};
        tv[7] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000020F, 0};

        do_reset();
        chk("rst_pp_write", pp_write, 0);
        chk("rst_pp_data", pp_data, 0);
        chk("rst_count", host_count, 0);
        chk("rst_full", host_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout_err, 0);

        for (int i = 0; i < 8; i++) begin
            host_wr   = tv[i].wr;
            host_data = tv[i].d;
            pru_done  = tv[i].done;
            tick();
            chk($sformatf("vec%0d_wr", i), pp_write, tv[i].e_wr);
            chk($sformatf("vec%0d_data", i), pp_data, tv[i].e_data);
            chk($sformatf("vec%0d_cnt", i), host_count, tv[i].e_cnt);
        end
        idle_inputs();

        do_reset();
        push(32'hA0);
        push(32'hA1);
        tp = cyc;
        push(32'hB0);
        push(32'hB1);
        wait_events(2, 20, "pair1_events");
        chk("pair1_w0_time", ev_cyc[0] - tp, 2);
        chk("pair1_w1_time", ev_cyc[1] - tp, 4);
        chk("pair1_w0_data", ev_dat[0], 32'hA0);
        chk("pair1_w1_data", ev_dat[1], 32'hA1);
        while (cyc < ev_cyc[1] + 8) tick();
        chk("pair2_held", ev_cyc.size(), 2);
        pru_done = 1'b1;
        tick();
        td = cyc;
        pru_done = 1'b0;
        wait_events(4, 20, "pair2_events");
        chk("pair2_w0_time", ev_cyc[2] - td, 2);
        chk("pair2_w1_time", ev_cyc[3] - td, 4);
        chk("pair2_w0_data", ev_dat[2], 32'hB0);
        chk("pair2_w1_data", ev_dat[3], 32'hB1);
        chk("pair2_count", host_count, 0);

        do_reset();
        pru_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            host_wr   = 1'b1;
            host_data = 32'(100 + i);
            tick();
            if (i == 14) chk("full_at15", host_full, 0);
            if (i == 15) begin
                chk("full_at16", host_full, 1);
                chk("ovf_at16", overflow, 0);
            end
        end
        chk("ovf_at17", overflow, 1);
        chk("count_at17", host_count, 16);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_prio", overflow, 0);
        flush = 1'b1;
        tick();
        flush   = 1'b0;
        host_wr = 1'b0;
        chk("flush_wr_ovf", overflow, 0);
        chk("flush_wr_count", host_count, 0);
        chk("flush_wr_full", host_full, 0);
        idle_inputs();

        do_reset();
        push(32'h11);
        repeat (50) tick();
        chk("lone_no_issue", ev_cyc.size(), 0);
        chk("lone_count", host_count, 1);
        push(32'h22);
        tp = cyc;
        wait_events(2, 20, "lone_events");
        chk("lone_w0_time", ev_cyc[0] - tp, 2);
        chk("lone_w1_time", ev_cyc[1] - tp, 4);
        chk("lone_w1_data", ev_dat[1], 32'h22);

        do_reset();
        pru_busy = 1'b1;
        push(32'hC0);
        push(32'hC1);
        push(32'hC2);
        push(32'hC3);
        pru_busy = 1'b0;
        tick();
        tick();
        chk("gap_w0_wr", pp_write, 1);
        chk("gap_w0_data", pp_data, 32'hC0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("gap_flush_count", host_count, 0);
        chk("gap_flush_wr", pp_write, 0);
        repeat (8) tick();
        chk("gap_no_w1", ev_cyc.size(), 1);
        push(32'hD0);
        push(32'hD1);
        tp = cyc;
        wait_events(3, 20, "post_flush_events");
        chk("post_flush_time", ev_cyc[1] - tp, 2);
        chk("post_flush_data", ev_dat[1], 32'hD0);

        do_reset();
        push(32'hE0);
        push(32'hE1);
        wait_word(32'hE1, "rst_mid_reach");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr", pp_write, 0);
        chk("rst_mid_data", pp_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef PRU_CMD_TIMEOUT_EN
        do_reset();
        push(32'hF0);
        push(32'hF1);
        wait_word(32'hF1, "tmo_reach");
        repeat (99) tick();
        chk("tmo_before", timeout_err, 0);
        tick();
        chk("tmo_set", timeout_err, 1);
        push(32'hF2);
        push(32'hF3);
        wait_word(32'hF2, "tmo_resume");
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("tmo_clr", timeout_err, 0);
`endif

        do_reset();
        q.delete();
        act    = 0;
        el     = 0;
        m_wr   = 0;
        m_data = '0;
        m_ovf  = 0;
        m_tmo  = 0;
        for (int n = 0; n < 3000; n++) begin
            host_wr   = ($urandom_range(0, 9) < 5);
            host_data = $urandom;
            pru_busy  = ($urandom_range(0, 3) == 0);
            pru_done  = ($urandom_range(0, 11) == 0);
            flush     = ($urandom_range(0, 63) == 0);
            clr_err   = ($urandom_range(0, 31) == 0);
            model_step(host_wr, host_data, pru_busy, pru_done, flush,
                       clr_err);
            tick();
            chk("rnd_wr", pp_write, m_wr);
            chk("rnd_data", pp_data, m_data);
            chk("rnd_count", host_count, q.size());
            chk("rnd_full", host_full, q.size() == DEPTH);
            chk("rnd_ovf", overflow, m_ovf);
            chk("rnd_tmo", timeout_err, m_tmo);
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
